// File: rtl/dump_pkg.sv
// Shared types for the register-dump reader; CSUM exists only when DUMP_CHECKSUM_EN is defined.
// No timing of its own: state encoding, word and byte geometry.
package dump_pkg;

  localparam int BYTES_PER_REG = 4;
  localparam int REG_W         = 32;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, LOAD, SEND, NEXT, CSUM, FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, LOAD, SEND, NEXT, FIN
  } state_t;
`endif

endpackage

// File: rtl/dump_byte_shifter.sv
// 32-bit word holder that presents its top byte and shifts left by one byte per request.
// dout valid the cycle after load; load wins over shift; holds while neither is asserted.
module dump_byte_shifter
  import dump_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [REG_W-1:0] din,
  output logic [7:0]       dout
);

  logic [REG_W-1:0] sr_q;
  logic [REG_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[REG_W-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[REG_W-1 -: 8];

endmodule

// File: rtl/reg_dump_reader.sv
// Streams NUM_REGS registers MSB-first as bytes over a valid/ready port; optional trailing XOR byte with DUMP_CHECKSUM_EN.
// 8 cycles per register at full rate; tx_data/tx_valid hold while tx_ready is low.
module reg_dump_reader
  import dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [REG_W-1:0]  rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_REG - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        bcnt_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              sh_load;
  logic              sh_shift;
  logic [7:0]        sh_dout;

  assign accept   = tx_valid_q & tx_ready;
  assign sh_load  = (state_q == LOAD);
  assign sh_shift = (state_q == SEND) & accept;

  dump_byte_shifter u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (rd_data),
    .dout  (sh_dout)
  );

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (sh_shift) begin
      csum_q <= csum_q ^ sh_dout;
    end
  end

  assign tx_data = (state_q == CSUM) ? csum_q : sh_dout;
`else
  assign tx_data = sh_dout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      bcnt_q     <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ADDR;
            idx_q     <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ADDR: state_q <= WAIT;
        WAIT: state_q <= LOAD;
        LOAD: begin
          state_q    <= SEND;
          bcnt_q     <= '0;
          tx_valid_q <= 1'b1;
        end
        SEND: begin
          if (accept) begin
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              state_q    <= NEXT;
            end
          end
        end
        NEXT: begin
          if (idx_q == LAST_IDX) begin
            rd_addr_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            state_q    <= CSUM;
            tx_valid_q <= 1'b1;
`else
            state_q <= FIN;
            done_q  <= 1'b1;
`endif
          end else begin
            idx_q     <= idx_q + ADDR_W'(1);
            rd_addr_q <= idx_q + ADDR_W'(1);
            state_q   <= ADDR;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FIN;
          end
        end
`endif
        // busy stays high through FIN so a start in that cycle is ignored
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table of dump scenarios against a byte-stream model, plus reset and NUM_REGS=1 sequences.
module tb_reg_dump_reader;

  localparam int N      = 32;
  localparam int BUDGET = 3000;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS_EXTRA = 1;
`else
  localparam int CS_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic        start1 = 1'b0;
  logic        tx_ready1 = 1'b0;
  logic [0:0]  rd_addr1;
  logic [31:0] rd_data1;
  logic [7:0]  tx_data1;
  logic        tx_valid1, busy1, done1;

  always #5 clk = ~clk;

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  reg_dump_reader #(.NUM_REGS(1), .ADDR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1), .done(done1)
  );

  // Register files with a registered read port
  logic [31:0] regs [N];
  always @(posedge clk) rd_data  <= regs[rd_addr];
  always @(posedge clk) rd_data1 <= (rd_addr1 == 1'b0) ? 32'hDEADBEEF : 32'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] got[$];
  logic [7:0] got1[$];
  logic [7:0] exp_q[$];
  int         done_cnt, hold_err, addr_err;
  logic       pend = 1'b0;
  logic [7:0] pend_dat;

  always @(negedge clk) begin
    if (rst_n && pend && !(tx_valid && tx_data == pend_dat)) hold_err++;
    pend     = rst_n && tx_valid && !tx_ready;
    pend_dat = tx_data;
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (done) done_cnt++;
    if (rst_n && !busy && rd_addr != 5'd0) addr_err++;
    if (tx_valid1 && tx_ready1) got1.push_back(tx_data1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < N; k++) begin
      case (pat)
        0:       regs[k] = 32'h01020300 + k;
        1:       regs[k] = $urandom;
        default: regs[k] = (k == 3) ? 32'h000000AA : 32'h0;
      endcase
    end
  endtask

  // Expected stream: each register's four bytes high to low, then the XOR of all of them if enabled
  task automatic build_expected();
    logic [7:0] cs;
    logic [31:0] w;
    exp_q.delete();
    cs = 8'h00;
    for (int k = 0; k < N; k++) begin
      w = regs[k];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        cs = cs ^ 8'((w >> (8 * b)) & 32'hFF);
      end
    end
    if (CS_EXTRA == 1) exp_q.push_back(cs);
  endtask

  // Caller is positioned just after a rising edge; start is raised immediately.
  task automatic run_dump(input string tag, input int rdy_pct, input int restart_at,
                          input bit fin_start, input bit chk_time);
    bit restarted;
    bit seen_done;
    int mism;
    int done_at;
    restarted = 0;
    seen_done = 0;
    done_at   = -1;
    got.delete();
    done_cnt = 0;
    hold_err = 0;
    addr_err = 0;
    start    = 1'b1;
    tx_ready = ($urandom_range(99) < rdy_pct);
    cyc      = 0;
    while (cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (done) begin
        seen_done = 1;
        done_at   = cyc;
        if (fin_start) start = 1'b1;
        break;
      end
      if (restart_at >= 0 && !restarted && got.size() >= restart_at) begin
        start     = 1'b1;
        restarted = 1;
      end
      tx_ready = ($urandom_range(99) < rdy_pct);
    end
    @(posedge clk);
    #1 start = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done_seen"}, 64'(seen_done), 64'd1);
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " byte_count"}, 64'(got.size()), 64'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) mism++;
    check({tag, " byte_mismatches"}, 64'(mism), 64'd0);
    check({tag, " hold_violations"}, 64'(hold_err), 64'd0);
    check({tag, " rd_addr_idle"}, 64'(addr_err), 64'd0);
    if (chk_time) check({tag, " cycles_to_done"}, 64'(done_at), 64'(8 * N + 1 + CS_EXTRA));
  endtask

  typedef struct {
    string name;
    int    pat;
    int    rdy;
    int    restart;
    bit    fin_start;
    bit    chk_time;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"incr_full",     0, 100, -1, 1'b0, 1'b1};
    vecs[1] = '{"incr_bp30",     0,  70, -1, 1'b0, 1'b0};
    vecs[2] = '{"restart_ign",   0, 100, 10, 1'b1, 1'b1};
    vecs[3] = '{"rand_bp50",     1,  50, -1, 1'b0, 1'b0};
    vecs[4] = '{"rand_bp15",     1,  85,  7, 1'b1, 1'b0};
    vecs[5] = '{"sparse_aa",     2, 100, -1, 1'b0, 1'b1};

    fill(0);
    #1;
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    check("reset_tx_data", 64'(tx_data), 64'd0);
    check("reset_tx_valid", 64'(tx_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat);
      build_expected();
      @(posedge clk);
      #1;
      run_dump(vecs[v].name, vecs[v].rdy, vecs[v].restart, vecs[v].fin_start, vecs[v].chk_time);
      if (vecs[v].pat == 0 && got.size() >= 128) begin
        check({vecs[v].name, " first_word"}, 64'({got[0], got[1], got[2], got[3]}), 64'h01020300);
        check({vecs[v].name, " last_word"}, 64'({got[124], got[125], got[126], got[127]}), 64'h0102031F);
      end
      if (vecs[v].pat == 2 && got.size() > 0) begin
        check("sparse_aa last_byte", 64'(got[got.size() - 1]), 64'(CS_EXTRA == 1 ? 8'hAA : 8'h00));
      end
    end

    // Reset asserted while register 5 is being sent
    fill(0);
    build_expected();
    @(posedge clk);
    #1 start = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 400; i++) begin
        if (rd_addr == 5'd5 && tx_valid) begin
          found = 1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("midreset reached_reg5_send", 64'(found), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midreset tx_valid", 64'(tx_valid), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset rd_addr", 64'(rd_addr), 64'd0);
    check("midreset tx_data", 64'(tx_data), 64'd0);
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_dump("after_reset", 100, -1, 1'b0, 1'b1);

    // Single-register instance
    got1.delete();
    @(posedge clk);
    #1 start1 = 1'b1;
    tx_ready1 = 1'b1;
    begin
      int c;
      c = 0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk);
        #1 start1 = 1'b0;
        c++;
        if (done1) break;
      end
      check("one_reg cycles_to_done", 64'(c), 64'(9 + CS_EXTRA));
    end
    repeat (3) @(posedge clk);
    #1 tx_ready1 = 1'b0;
    check("one_reg busy_after", 64'(busy1), 64'd0);
    check("one_reg byte_count", 64'(got1.size()), 64'(4 + CS_EXTRA));
    if (got1.size() >= 4)
      check("one_reg bytes", 64'({got1[0], got1[1], got1[2], got1[3]}), 64'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
